alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational 16-op ALU.
- Same opcode set; operand width and pipeline depth are configurable.
- Adds valid/ready handshakes on input and output, a pass-through tag, and a status-flag output.
- Sits between the issue stage and writeback. Backpressure from writeback stalls the pipe with no loss or duplication.

---
 rtl/alu_pipe.sv | 156 +++++++++++++++
 tb/tb_alu_pipe.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined 16-op ALU with valid/ready handshakes, pass-through tag and {C,V,N,ZF} flags.
// Optional feature macro ALU_PIPE_SAT_EN: ops 0 and 8 saturate on signed overflow.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       INST,
  input  logic             SEL,
  input  logic [TAG_W-1:0] TAG_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Z,
  output logic [TAG_W-1:0] TAG_OUT,
  output logic [3:0]       FLAGS
);

  logic [WIDTH:0]   add_sum, sub_sum;
  logic [WIDTH-1:0] neg_res, res;
  logic             add_ovf, sub_ovf, neg_ovf, lt, eq, c_bit, v_bit;
  logic [3:0]       flags_new;

  assign add_sum = {1'b0, A} + {1'b0, B};
  assign sub_sum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign neg_res = ~A + {{(WIDTH-1){1'b0}}, 1'b1};
  assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
  assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);
  // only -MIN stays negative after negation
  assign neg_ovf = A[WIDTH-1] && neg_res[WIDTH-1];
  assign lt      = $signed(A) < $signed(B);
  assign eq      = (A == B);

`ifdef ALU_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  logic [WIDTH-1:0] sat_val;
  // overflow direction follows the sign of A for both add and subtract
  assign sat_val = A[WIDTH-1] ? ~MAX_V : MAX_V;
`endif

  always_comb begin
    res   = '0;
    c_bit = 1'b0;
    v_bit = 1'b0;
    case (INST)
      4'd0: begin
        res   = add_sum[WIDTH-1:0];
        c_bit = add_sum[WIDTH];
        v_bit = add_ovf;
`ifdef ALU_PIPE_SAT_EN
        if (add_ovf) res = sat_val;
`endif
      end
      4'd1: begin
        res   = neg_res;
        v_bit = neg_ovf;
      end
      4'd2:  res = A & B;
      4'd3:  res = A | B;
      4'd4:  res = A ^ B;
      4'd5:  res = ~A;
      4'd6:  res = SEL ? B : A;
      4'd7:  res = SEL ? A : B;
      4'd8: begin
        res   = sub_sum[WIDTH-1:0];
        c_bit = sub_sum[WIDTH];
        v_bit = sub_ovf;
`ifdef ALU_PIPE_SAT_EN
        if (sub_ovf) res = sat_val;
`endif
      end
      4'd9:  res = {{(WIDTH-1){1'b0}}, lt};
      4'd10: res = {{(WIDTH-1){1'b0}}, lt | eq};
      4'd11: res = {{(WIDTH-1){1'b0}}, ~(lt | eq)};
      4'd12: res = {{(WIDTH-1){1'b0}}, ~lt};
      4'd13: res = {{(WIDTH-1){1'b0}}, eq};
      4'd14: res = {{(WIDTH-1){1'b0}}, ~eq};
      default: res = {{(WIDTH-1){1'b0}}, SEL ^ B[0]};
    endcase
    flags_new = {c_bit, v_bit, res[WIDTH-1], (res == '0)};
  end

  logic [STAGES-1:0] vld_q, vld_d, load;
  logic [WIDTH-1:0]  z_q   [STAGES];
  logic [WIDTH-1:0]  z_d   [STAGES];
  logic [3:0]        flg_q [STAGES];
  logic [3:0]        flg_d [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];
  logic              in_fire;

  // a stage may load if it, or any stage after it, is empty, or the output drains
  always_comb begin
    logic acc;
    acc  = OUT_READY;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc     = acc | ~vld_q[k];
      load[k] = acc;
    end
  end

  assign IN_READY = RST_N & load[0];
  assign in_fire  = IN_VALID & IN_READY;

  always_comb begin
    vld_d = vld_q;
    z_d   = z_q;
    flg_d = flg_q;
    tag_d = tag_q;
    if (load[0]) vld_d[0] = in_fire;
    if (in_fire) begin
      z_d[0]   = res;
      flg_d[0] = flags_new;
      tag_d[0] = TAG_IN;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        vld_d[k] = vld_q[k-1];
        // payload only moves with a valid op so an empty output holds its last value
        if (vld_q[k-1]) begin
          z_d[k]   = z_q[k-1];
          flg_d[k] = flg_q[k-1];
          tag_d[k] = tag_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        z_q[k]   <= '0;
        flg_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      z_q   <= z_d;
      flg_q <= flg_d;
      tag_q <= tag_d;
    end
  end

  assign OUT_VALID = vld_q[STAGES-1];
  assign Z         = z_q[STAGES-1];
  assign FLAGS     = flg_q[STAGES-1];
  assign TAG_OUT   = tag_q[STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe; three instances (W32/S2, W8/S1, W64/S4)
// checked against an arithmetic reference model using wide signed integers.
module tb_alu_pipe;

  typedef struct packed {
    logic [63:0] z;
    logic [3:0]  f;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        sel       [3];
  logic [63:0] a_s       [3];
  logic [63:0] b_s       [3];
  logic [3:0]  inst      [3];
  logic [3:0]  tag_in    [3];
  logic [3:0]  tag_o     [3];
  logic [3:0]  flags_o   [3];
  logic [63:0] z_s       [3];
  logic [31:0] z0;
  logic [7:0]  z1;
  logic [63:0] z2;

  exp_t cur_exp [3];
  exp_t held    [3];
  bit   stalled [3];
  int   acc_cnt [3];
  exp_t q0[$], q1[$], q2[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
    .A(a_s[0][31:0]), .B(b_s[0][31:0]), .INST(inst[0]), .SEL(sel[0]), .TAG_IN(tag_in[0]),
    .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]), .Z(z0), .TAG_OUT(tag_o[0]), .FLAGS(flags_o[0]));

  alu_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(4)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
    .A(a_s[1][7:0]), .B(b_s[1][7:0]), .INST(inst[1]), .SEL(sel[1]), .TAG_IN(tag_in[1]),
    .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]), .Z(z1), .TAG_OUT(tag_o[1]), .FLAGS(flags_o[1]));

  alu_pipe #(.WIDTH(64), .STAGES(4), .TAG_W(4)) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid[2]), .IN_READY(in_ready[2]),
    .A(a_s[2]), .B(b_s[2]), .INST(inst[2]), .SEL(sel[2]), .TAG_IN(tag_in[2]),
    .OUT_VALID(out_valid[2]), .OUT_READY(out_ready[2]), .Z(z2), .TAG_OUT(tag_o[2]), .FLAGS(flags_o[2]));

  always_comb begin
    z_s[0] = {32'd0, z0};
    z_s[1] = {56'd0, z1};
    z_s[2] = z2;
  end

  function automatic logic [63:0] mask_of(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference model: operands as exact signed integers, overflow = result outside the w-bit range.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                input logic [3:0] op, input logic s,
                                output logic [63:0] z, output logic [3:0] f);
    logic signed [127:0] full, half, sa, sb, t, mx;
    logic [127:0]        ua, ub, ufull;
    logic                c, v;
    full  = 128'sd1 <<< w;
    half  = full >>> 1;
    ufull = full;
    ua    = {64'd0, a & mask_of(w)};
    ub    = {64'd0, b & mask_of(w)};
    sa    = $signed(ua);
    sb    = $signed(ub);
    if (sa >= half) sa = sa - full;
    if (sb >= half) sb = sb - full;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0:  begin t = sa + sb; c = ((ua + ub) >= ufull); v = (t >= half) || (t < -half); end
      4'd1:  begin t = -sa; v = (t >= half); end
      4'd2:  t = sa & sb;
      4'd3:  t = sa | sb;
      4'd4:  t = sa ^ sb;
      4'd5:  t = ~sa;
      4'd6:  t = s ? sb : sa;
      4'd7:  t = s ? sa : sb;
      4'd8:  begin t = sa - sb; c = (ua >= ub); v = (t >= half) || (t < -half); end
      4'd9:  t = (sa <  sb) ? 128'sd1 : 128'sd0;
      4'd10: t = (sa <= sb) ? 128'sd1 : 128'sd0;
      4'd11: t = (sa >  sb) ? 128'sd1 : 128'sd0;
      4'd12: t = (sa >= sb) ? 128'sd1 : 128'sd0;
      4'd13: t = (sa == sb) ? 128'sd1 : 128'sd0;
      4'd14: t = (sa != sb) ? 128'sd1 : 128'sd0;
      default: t = (s ^ ub[0]) ? 128'sd1 : 128'sd0;
    endcase
    z = t[63:0] & mask_of(w);
`ifdef ALU_PIPE_SAT_EN
    mx = half - 128'sd1;
    if (v && (op == 4'd0 || op == 4'd8)) z = (t > 0) ? mx[63:0] : (~mx[63:0] & mask_of(w));
`else
    mx = '0;
`endif
    f = {c, v, z[w-1], (z == 64'd0)};
  endfunction

  function automatic void q_push(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int q_size(input int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_pop(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void q_flush(input int d);
    case (d)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // acceptor: records the expected response at each input transfer
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_n && in_valid[d] && in_ready[d]) begin
        q_push(d, cur_exp[d]);
        acc_cnt[d]++;
      end
    end
  end

  // monitor: pops and compares at each output transfer; checks hold while stalled
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        q_flush(d);
        stalled[d] = 1'b0;
      end else begin
        if (stalled[d])
          chk($sformatf("hold_d%0d", d), {out_valid[d], z_s[d], flags_o[d], tag_o[d]}, {1'b1, held[d]});
        if (out_valid[d] && out_ready[d]) begin
          if (q_size(d) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out_d%0d actual z=%0h tag=%0h required none", d, z_s[d], tag_o[d]);
          end else begin
            exp_t e;
            e = q_pop(d);
            chk($sformatf("out_d%0d", d), {z_s[d], flags_o[d], tag_o[d]}, e);
          end
        end
        stalled[d] = out_valid[d] && !out_ready[d];
        held[d]    = '{z_s[d], flags_o[d], tag_o[d]};
      end
    end
  end

  task automatic set_op_k(input int d, input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                          input logic s, input logic [3:0] tg, input logic [63:0] ez, input logic [3:0] ef);
    a_s[d] = a; b_s[d] = b; inst[d] = op; sel[d] = s; tag_in[d] = tg;
    cur_exp[d]  = '{ez, ef, tg};
    in_valid[d] = 1'b1;
  endtask

  task automatic set_op(input int d, input int w, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] op, input logic s, input logic [3:0] tg);
    logic [63:0] z;
    logic [3:0]  f;
    model(w, a, b, op, s, z, f);
    set_op_k(d, a & mask_of(w), b & mask_of(w), op, s, tg, z, f);
  endtask

  // entered at posedge+1 with an op presented; returns at posedge+1 after the transfer
  task automatic wait_accept(input int d);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready[d];
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept_timeout_d%0d actual in_ready=0 required 1", d);
    end
  endtask

  task automatic drain(input int d);
    int n = 0;
    out_ready[d] = 1'b1;
    while ((q_size(d) != 0 || out_valid[d]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL drain_timeout_d%0d actual pending=%0d required 0", d, q_size(d));
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rnd(input int w);
    logic [63:0] h, r;
    h = 64'd1 << (w - 1);
    case ($urandom_range(0, 7))
      0: r = h;
      1: r = h - 64'd1;
      2: r = 64'd0;
      3: r = 64'hFFFF_FFFF_FFFF_FFFF;
      4: r = 64'd1;
      default: r = {$urandom, $urandom};
    endcase
    return r & mask_of(w);
  endfunction

  task automatic rand_run(input int d, input int w, input int n);
    int sent = 0;
    int cyc  = 0;
    bit fired;
    out_ready[d] = 1'b1;
    in_valid[d]  = 1'b0;
    while (sent < n && cyc < 40 * n) begin
      if (!in_valid[d]) begin
        if ($urandom_range(0, 4) != 0)
          set_op(d, w, rnd(w), rnd(w), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
        else begin
          a_s[d] = {$urandom, $urandom};
          b_s[d] = {$urandom, $urandom};
        end
      end
      @(negedge clk);
      fired = in_valid[d] && in_ready[d];
      @(posedge clk); #1;
      cyc++;
      if (fired) begin
        sent++;
        in_valid[d] = 1'b0;
      end
      out_ready[d] = ($urandom_range(0, 3) != 0);
    end
    in_valid[d] = 1'b0;
    chk($sformatf("rand_sent_d%0d", d), sent, n);
    drain(d);
  endtask

  initial begin
    int a0, streak, seen;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1; sel[d] = 1'b0;
      a_s[d] = '0; b_s[d] = '0; inst[d] = '0; tag_in[d] = '0;
      cur_exp[d] = '0; held[d] = '0; stalled[d] = 1'b0; acc_cnt[d] = 0;
    end

    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid[0], 0);
      chk("rst_z", z_s[0], 0);
      chk("rst_flags", flags_o[0], 0);
      chk("rst_tag", tag_o[0], 0);
      chk("rst_in_ready", in_ready[0], 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready[0], 1);
    @(posedge clk); #1;

    set_op_k(0, 64'd5, 64'd7, 4'd0, 1'b0, 4'd3, 64'd12, 4'b0000);
    wait_accept(0);
    @(negedge clk);
    chk("lat_early", out_valid[0], 0);
    @(negedge clk);
    chk("lat_valid", out_valid[0], 1);
    chk("lat_z", z_s[0], 64'd12);
    chk("lat_tag", tag_o[0], 3);
    chk("lat_flags", flags_o[0], 4'b0000);
    @(posedge clk); #1;

`ifdef ALU_PIPE_SAT_EN
    set_op_k(0, 64'h7FFF_FFFF, 64'd1, 4'd0, 1'b0, 4'd1, 64'h7FFF_FFFF, 4'b0100); wait_accept(0);
`else
    set_op_k(0, 64'h7FFF_FFFF, 64'd1, 4'd0, 1'b0, 4'd1, 64'h8000_0000, 4'b0110); wait_accept(0);
`endif
    set_op_k(0, 64'hFFFF_FFFF, 64'd1, 4'd9,  1'b0, 4'd2, 64'd1, 4'b0000); wait_accept(0);
    set_op_k(0, 64'hFFFF_FFFF, 64'd1, 4'd11, 1'b0, 4'd3, 64'd0, 4'b0001); wait_accept(0);
    set_op_k(0, 64'd3, 64'd3, 4'd8, 1'b0, 4'd4, 64'd0, 4'b1001); wait_accept(0);
    set_op_k(0, 64'h8000_0000, 64'd0, 4'd1, 1'b0, 4'd5, 64'h8000_0000, 4'b0110); wait_accept(0);
    set_op_k(0, 64'd0, 64'd1, 4'd15, 1'b1, 4'd6, 64'd0, 4'b0001); wait_accept(0);
    drain(0);

    // backpressure: pipe of 2 fills, then streams one per cycle
    out_ready[0] = 1'b0;
    a0 = acc_cnt[0];
    set_op(0, 32, rnd(32), rnd(32), 4'd0, 1'b0, 4'd0); wait_accept(0);
    set_op(0, 32, rnd(32), rnd(32), 4'd4, 1'b0, 4'd1); wait_accept(0);
    set_op(0, 32, rnd(32), rnd(32), 4'd8, 1'b0, 4'd2);
    @(negedge clk);
    chk("full_in_ready", in_ready[0], 0);
    @(negedge clk);
    chk("full_accepts", acc_cnt[0] - a0, 2);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    streak = 0;
    fork
      begin
        wait_accept(0);
        for (int t = 3; t < 6; t++) begin
          set_op(0, 32, rnd(32), rnd(32), 4'($urandom_range(0, 15)), 1'b1, 4'(t));
          wait_accept(0);
        end
      end
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (out_valid[0]) streak++;
        end
      end
    join
    chk("stream_streak", streak, 6);
    drain(0);

    // bubble collapse
    out_ready[0] = 1'b0;
    a0 = acc_cnt[0];
    set_op(0, 32, rnd(32), rnd(32), 4'd3, 1'b0, 4'd1); wait_accept(0);
    @(posedge clk); #1;
    set_op(0, 32, rnd(32), rnd(32), 4'd12, 1'b0, 4'd2); wait_accept(0);
    repeat (4) @(negedge clk);
    chk("bubble_out_valid", out_valid[0], 1);
    chk("bubble_in_ready", in_ready[0], 0);
    chk("bubble_accepts", acc_cnt[0] - a0, 2);
    @(posedge clk); #1;
    drain(0);

    // mid-operation reset discards in-flight ops
    out_ready[0] = 1'b0;
    set_op(0, 32, rnd(32), rnd(32), 4'd0, 1'b0, 4'd7); wait_accept(0);
    set_op(0, 32, rnd(32), rnd(32), 4'd1, 1'b0, 4'd8); wait_accept(0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid[0], 0);
    chk("midrst_in_ready", in_ready[0], 1);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    chk("midrst_no_output", seen, 0);
    @(posedge clk); #1;

    rand_run(0, 32, 1024);
    rand_run(1, 8, 512);
    rand_run(2, 64, 512);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
